// File: rtl/image_loader_if.sv
// Pixel byte stream (valid/ready) and framebuffer RAM write port.
// The loader takes the slave view; the source/RAM side takes the master view.
interface image_loader_if #(
    parameter int ADDR_W = 16
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/image_loader.sv
// Streams 8-bit gray pixels into the framebuffer RAM in raster order,
// one pixel per word, and flags completion or an inter-byte stall timeout.
module image_loader #(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    image_loader_if.slave     bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   pixel_count
);
    localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [31:0] EXPIRE_AT = (TIMEOUT > 1) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DONE, ERROR} state_t;

    state_t         state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [31:0]    idle_cnt;
    logic           accept;
    logic           last_pixel;
    logic           expire;

    assign bus.in_ready = (state == LOAD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_pixel   = (x == X_W'(IMG_W - 1)) && (y == Y_W'(IMG_H - 1));
    // The counter is compared on its next value, so the error state is
    // entered after TIMEOUT-1 silent cycles and becomes visible one later.
    assign expire       = (TIMEOUT != 0) && !accept && ((idle_cnt + 32'd1) >= EXPIRE_AT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            idle_cnt    <= '0;
            pixel_count <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            bus.wr_en <= accept;
            if (accept) begin
                bus.wr_addr <= ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
                bus.wr_data <= {24'b0, bus.in_data};
            end
            if (bus.wr_en) begin
                pixel_count <= pixel_count + (ADDR_W + 1)'(1);
            end

            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state       <= LOAD;
                        x           <= '0;
                        y           <= '0;
                        idle_cnt    <= '0;
                        pixel_count <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        err         <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (x == X_W'(IMG_W - 1)) begin
                            x <= '0;
                            y <= y + Y_W'(1);
                        end else begin
                            x <= x + X_W'(1);
                        end
                        if (last_pixel) begin
                            state <= FLUSH;
                        end
                    end else if (expire) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                FLUSH: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader on a 4x2 image: one instance with the
// timeout disabled, one with TIMEOUT=5, both fed from the same stimulus.
module tb_image_loader;
    localparam int W = 4;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;

    logic        busy0, done0, err0, busy5, done5, err5;
    logic [16:0] pc0, pc5;

    int n_cmp  = 0;
    int n_fail = 0;

    image_loader_if #(.ADDR_W(16)) bus0 ();
    image_loader_if #(.ADDR_W(16)) bus5 ();

    assign bus0.in_valid = in_valid;
    assign bus0.in_data  = in_data;
    assign bus5.in_valid = in_valid;
    assign bus5.in_data  = in_data;

    image_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .bus(bus0),
        .busy(busy0), .done(done0), .err(err0), .pixel_count(pc0)
    );

    image_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .TIMEOUT(5)) dut5 (
        .clk(clk), .reset(reset), .start(start), .bus(bus5),
        .busy(busy5), .done(done5), .err(err5), .pixel_count(pc5)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [53:0] got;
        do_reset();
        got = {bus0.wr_en, bus0.wr_addr, bus0.wr_data, bus0.in_ready, busy0, done0, err0};
        n_cmp++;
        if (got !== 54'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", got);
        end
        n_cmp++;
        if (pc0 !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_pixel_count: got %0d expected 0", pc0);
        end
    endtask

    task automatic test_no_timeout();
        do_reset();
        do_start();
        in_valid = 1'b0;
        repeat (12) step();
        n_cmp++;
        if ({err0, busy0, bus0.in_ready} !== 3'b011) begin
            n_fail++;
            $display("[TB] FAIL no_timeout_state: got err/busy/rdy=%b expected 011", {err0, busy0, bus0.in_ready});
        end
        n_cmp++;
        if ({err5, busy5} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL timeout5_idle_err: got err/busy=%b expected 10", {err5, busy5});
        end
    endtask

    task automatic test_stream();
        logic [48:0] exp_w;
        logic [48:0] got_w;
        do_reset();
        do_start();
        for (int i = 0; i < W * H; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            n_cmp++;
            if (bus0.in_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, bus0.in_ready);
            end
            if (i > 0) begin
                exp_w = {1'b1, 16'(i - 1), 32'(16 + i - 1)};
                got_w = {bus0.wr_en, bus0.wr_addr, bus0.wr_data};
                n_cmp++;
                if (got_w !== exp_w) begin
                    n_fail++;
                    $display("[TB] FAIL stream_write[%0d]: got %h expected %h", i - 1, got_w, exp_w);
                end
            end
            step();
        end
        exp_w = {1'b1, 16'd7, 32'h17};
        got_w = {bus0.wr_en, bus0.wr_addr, bus0.wr_data};
        n_cmp++;
        if ({got_w, bus0.in_ready, busy0, done0} !== {exp_w, 3'b010}) begin
            n_fail++;
            $display("[TB] FAIL stream_flush: got %h/%b expected %h/010", got_w, {bus0.in_ready, busy0, done0}, exp_w);
        end
        step();
        n_cmp++;
        if ({done0, busy0, bus0.wr_en, pc0} !== {3'b100, 17'd8}) begin
            n_fail++;
            $display("[TB] FAIL stream_done: got done/busy/wr=%b count=%0d expected 100 count=8", {done0, busy0, bus0.wr_en}, pc0);
        end
    endtask

    task automatic test_done_hold();
        logic [48:0] got_w;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({bus0.in_ready, bus0.wr_en, done0} !== 3'b001) begin
                n_fail++;
                $display("[TB] FAIL done_hold[%0d]: got rdy/wr/done=%b expected 001", k, {bus0.in_ready, bus0.wr_en, done0});
            end
            step();
        end
        do_start();
        n_cmp++;
        if ({done0, busy0, bus0.in_ready, pc0} !== {3'b011, 17'd0}) begin
            n_fail++;
            $display("[TB] FAIL done_restart: got done/busy/rdy=%b count=%0d expected 011 count=0", {done0, busy0, bus0.in_ready}, pc0);
        end
        step();
        in_valid = 1'b0;
        got_w = {bus0.wr_en, bus0.wr_addr, bus0.wr_data};
        n_cmp++;
        if (got_w !== {1'b1, 16'd0, 32'h000000AA}) begin
            n_fail++;
            $display("[TB] FAIL done_reload_write: got %h expected %h", got_w, {1'b1, 16'd0, 32'h000000AA});
        end
    endtask

    task automatic test_toggle();
        logic [48:0] exp_w;
        logic [48:0] got_w;
        do_reset();
        do_start();
        for (int i = 0; i < W * H; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            if (i > 0) begin
                exp_w = {1'b0, 16'(i - 1), 32'(16 + i - 1)};
                got_w = {bus0.wr_en, bus0.wr_addr, bus0.wr_data};
                n_cmp++;
                if ({got_w, bus0.in_ready} !== {exp_w, 1'b1}) begin
                    n_fail++;
                    $display("[TB] FAIL toggle_gap[%0d]: got %h rdy=%b expected %h rdy=1", i, got_w, bus0.in_ready, exp_w);
                end
            end
            step();
            in_valid = 1'b0;
            exp_w = {1'b1, 16'(i), 32'(16 + i)};
            got_w = {bus0.wr_en, bus0.wr_addr, bus0.wr_data};
            n_cmp++;
            if ({got_w, bus0.in_ready} !== {exp_w, (i != W * H - 1)}) begin
                n_fail++;
                $display("[TB] FAIL toggle_write[%0d]: got %h rdy=%b expected %h", i, got_w, bus0.in_ready, exp_w);
            end
            step();
        end
        n_cmp++;
        if ({done0, pc0} !== {1'b1, 17'd8}) begin
            n_fail++;
            $display("[TB] FAIL toggle_done: got done=%b count=%0d expected done=1 count=8", done0, pc0);
        end
    endtask

    task automatic test_timeout();
        logic [48:0] got_w;
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h20 + i);
            step();
        end
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if ({err5, busy5, bus5.wr_en} !== {2'b01, (k == 1)}) begin
                n_fail++;
                $display("[TB] FAIL timeout_idle[%0d]: got err/busy/wr=%b expected 01%b", k, {err5, busy5, bus5.wr_en}, (k == 1));
            end
            step();
        end
        n_cmp++;
        if ({err5, busy5, bus5.in_ready, bus5.wr_en, pc5} !== {4'b1000, 17'd3}) begin
            n_fail++;
            $display("[TB] FAIL timeout_err: got err/busy/rdy/wr=%b count=%0d expected 1000 count=3", {err5, busy5, bus5.in_ready, bus5.wr_en}, pc5);
        end
        in_valid = 1'b1;
        in_data  = 8'h55;
        step();
        step();
        n_cmp++;
        if ({err5, bus5.wr_en, pc5} !== {2'b10, 17'd3}) begin
            n_fail++;
            $display("[TB] FAIL timeout_hold: got err/wr=%b count=%0d expected 10 count=3", {err5, bus5.wr_en}, pc5);
        end
        do_start();
        n_cmp++;
        if ({err5, busy5, pc5} !== {2'b01, 17'd0}) begin
            n_fail++;
            $display("[TB] FAIL timeout_restart: got err/busy=%b count=%0d expected 01 count=0", {err5, busy5}, pc5);
        end
        step();
        in_valid = 1'b0;
        got_w = {bus5.wr_en, bus5.wr_addr, bus5.wr_data};
        n_cmp++;
        if (got_w !== {1'b1, 16'd0, 32'h55}) begin
            n_fail++;
            $display("[TB] FAIL timeout_restart_write: got %h expected %h", got_w, {1'b1, 16'd0, 32'h55});
        end
    endtask

    task automatic test_accept_on_expiry();
        logic [48:0] got_w;
        step();
        step();
        step();
        in_valid = 1'b1;
        in_data  = 8'h66;
        n_cmp++;
        if ({err5, busy5, bus5.in_ready} !== 3'b011) begin
            n_fail++;
            $display("[TB] FAIL expiry_cycle_state: got err/busy/rdy=%b expected 011", {err5, busy5, bus5.in_ready});
        end
        step();
        in_valid = 1'b0;
        got_w = {bus5.wr_en, bus5.wr_addr, bus5.wr_data};
        n_cmp++;
        if ({got_w, err5} !== {1'b1, 16'd1, 32'h66, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL expiry_accept_write: got %h err=%b expected %h err=0", got_w, err5, {1'b1, 16'd1, 32'h66});
        end
        step();
        step();
        step();
        n_cmp++;
        if (err5 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL expiry_counter_restart: got err=%b expected 0", err5);
        end
        step();
        n_cmp++;
        if ({err5, pc5} !== {1'b1, 17'd2}) begin
            n_fail++;
            $display("[TB] FAIL expiry_second_err: got err=%b count=%0d expected err=1 count=2", err5, pc5);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [53:0] got;
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h30 + i);
            step();
        end
        in_data = 8'h35;
        reset   = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        got = {bus0.wr_en, bus0.wr_addr, bus0.wr_data, bus0.in_ready, busy0, done0, err0};
        n_cmp++;
        if ({got, pc0} !== 71'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_load: got %h count=%0d expected 0", got, pc0);
        end
        step();
        n_cmp++;
        if ({bus0.wr_en, busy0, pc0} !== 19'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_load_after: got wr/busy=%b count=%0d expected 0", {bus0.wr_en, busy0}, pc0);
        end
    endtask

    initial begin
        test_reset();
        test_no_timeout();
        test_stream();
        test_done_hold();
        test_toggle();
        test_timeout();
        test_accept_on_expiry();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Fills the grayscale framebuffer RAM that the VGA paint stage reads, one pixel per RAM word.
- Accepts an 8-bit pixel byte stream (e.g. from a UART receiver) using a valid/ready handshake.
- Writes pixels in raster order to addresses `y*IMG_W + x`, then reports completion or a stall timeout.
- Sits upstream of the framebuffer RAM write port; the display stage owns the read port.

Parameters:
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in pixels
- ADDR_W, 16, RAM address width; IMG_W*IMG_H must be <= 2**ADDR_W
- TIMEOUT, 50000000, idle cycles allowed between accepted bytes in LOAD; 0 disables the timeout

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins a new load from IDLE, DONE or ERROR
- in_valid  in  1  in_data holds a pixel byte
- in_data  in  8  pixel gray value
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  32  RAM write data, equal to {24'b0, pixel}
- busy  out  1  high in LOAD and FLUSH states
- done  out  1  high in DONE state
- err  out  1  high in ERROR state
- pixel_count  out  ADDR_W+1  number of pixels written since the last start

Behaviour:
- One clock and synchronous active-high reset (clk, reset).
- Reset forces: state IDLE; all outputs 0; x, y, pixel_count and timeout counter cleared.
- A write pending at reset is discarded: wr_en is 0 on the cycle after reset.
- States are IDLE, LOAD, FLUSH, DONE, ERROR.
- IDLE:
  - in_ready=0.
  - start moves to LOAD next cycle and clears x, y, pixel_count and the timeout counter.
- LOAD:
  - in_ready=1, driven combinationally from the state.
  - Accept means in_valid && in_ready.
  - On accept, the write is registered. On the next cycle wr_en=1, wr_addr = y*IMG_W + x (values captured at accept) and wr_data = {24'b0, in_data}.
  - Latency from accept to write is exactly 1 cycle. Back-to-back accepts give back-to-back writes.
  - With no accept on a cycle, the next cycle has wr_en=0, and wr_addr/wr_data hold their last values.
  - x increments on each accept. When x = IMG_W-1, x wraps to 0 and y increments.
  - pixel_count increments on the write cycle.
  - The accept of the pixel at x=IMG_W-1, y=IMG_H-1 moves the state to FLUSH; in_ready is 0 from the next cycle.
  - The timeout counter clears on each accept and increments otherwise. When it reaches TIMEOUT-1 with no accept that cycle, the state moves to ERROR.
  - If an accept and timeout expiry coincide, the accept wins and the counter clears.
  - start during LOAD is ignored.
- FLUSH:
  - Lasts one cycle and carries the final write (wr_en=1).
  - Then moves to DONE.
- DONE:
  - done=1, and pixel_count = IMG_W*IMG_H.
  - Holds until start (goes to LOAD and clears done) or reset.
- ERROR:
  - err=1, in_ready=0, and pixel_count is frozen at the number of pixels written.
  - Holds until start (goes to LOAD and clears err) or reset.
- Bytes presented while in_ready=0 are not consumed. The upstream source must hold them.
- No address is ever written twice within one load.
- No address >= IMG_W*IMG_H is ever written.

Test Plan:
- IMG_W=4, IMG_H=2, TIMEOUT=0. Reset, start, then stream bytes 0x10..0x17 with in_valid held high.
  - Required: 8 consecutive wr_en pulses with wr_addr 0..7 and wr_data 0x00000010..0x00000017.
  - done=1 two cycles after the last accept; pixel_count=8.
- Same setup with in_valid toggling 1/0 every cycle.
  - Required: the writes are spaced 2 cycles apart with the same addresses and data.
  - in_ready stays 1 throughout LOAD.
- TIMEOUT=5. Send 3 bytes, then hold in_valid low.
  - Required: err=1 in the 5th idle cycle after the last accept; busy=0; pixel_count=3; no further writes.
  - A following start returns to LOAD with addresses restarting at 0.
- Reset asserted on the accept cycle of pixel 5 during a load.
  - Required: no write occurs for pixel 5, and all outputs are 0 on the next cycle.
- In DONE, keep in_valid=1 with data 0xAA.
  - Required: in_ready=0 and no wr_en while in DONE.
  - A start pulse reloads from address 0, and the first write carries 0x000000AA.
- TIMEOUT=5 with an accept landing exactly on the expiry cycle.
  - Required: stays in LOAD, the counter restarts and the write occurs.
